// File: rtl/quad_encoder_if.sv
// Command and output bundle for the quadrature encoder pattern generator.
// The master side issues step commands; the slave side produces the A/B waveform.
interface quad_encoder_if #(
    parameter int COUNT_WIDTH  = 8,
    parameter int PERIOD_WIDTH = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_dir;
    logic [COUNT_WIDTH-1:0]  cmd_steps;
    logic [PERIOD_WIDTH-1:0] cmd_period;
    logic                    abort;
    logic                    enc_a;
    logic                    enc_b;
    logic [7:0]              position;
    logic                    busy;
    logic                    done;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
        input  cmd_ready, enc_a, enc_b, position, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
        output cmd_ready, enc_a, enc_b, position, busy, done
    );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder generator: emits a programmed number of A/B edges at a fixed
// clock spacing in either direction and tracks the signed net edge count.
module quad_encoder_gen #(
    parameter int COUNT_WIDTH  = 8,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    quad_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r;
    logic [1:0]              phase_r;
    logic [1:0]              phase_step_s;
    logic [7:0]              position_r;
    logic [7:0]              position_step_s;
    logic [PERIOD_WIDTH-1:0] interval_r;
    logic [PERIOD_WIDTH-1:0] reload_r;
    logic [PERIOD_WIDTH-1:0] load_s;
    logic [COUNT_WIDTH-1:0]  remaining_r;
    logic                    dir_r;
    logic                    enc_a_r;
    logic                    enc_b_r;
    logic                    ready_r;
    logic                    busy_r;
    logic                    done_r;

    // Gray-style phase to {A,B} mapping: 00, 10, 11, 01.
    function automatic logic [1:0] phase_to_ab(input logic [1:0] p);
        logic [1:0] ab;
        case (p)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b10;
            2'd2:    ab = 2'b11;
            2'd3:    ab = 2'b01;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    // Next phase/position for one edge in the latched direction.
    always_comb begin
        phase_step_s    = phase_r;
        position_step_s = position_r;
        if (dir_r) begin
            phase_step_s    = phase_r + 2'd1;
            position_step_s = position_r + 8'd1;
        end else begin
            phase_step_s    = phase_r - 2'd1;
            position_step_s = position_r - 8'd1;
        end
    end

    // Interval reload value; a zero period behaves as one clock per edge.
    always_comb begin
        load_s = {PERIOD_WIDTH{1'b0}};
        if (bus.cmd_period == {PERIOD_WIDTH{1'b0}}) begin
            load_s = {PERIOD_WIDTH{1'b0}};
        end else begin
            load_s = bus.cmd_period - PERIOD_WIDTH'(1);
        end
    end

    // Command FSM, edge scheduler and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            phase_r     <= 2'd0;
            position_r  <= 8'd0;
            interval_r  <= {PERIOD_WIDTH{1'b0}};
            reload_r    <= {PERIOD_WIDTH{1'b0}};
            remaining_r <= {COUNT_WIDTH{1'b0}};
            dir_r       <= 1'b0;
            enc_a_r     <= 1'b0;
            enc_b_r     <= 1'b0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.cmd_valid && ready_r) begin
                        dir_r       <= bus.cmd_dir;
                        reload_r    <= load_s;
                        interval_r  <= load_s;
                        remaining_r <= bus.cmd_steps;
                        ready_r     <= 1'b0;
                        busy_r      <= 1'b1;
                        if (bus.cmd_steps == {COUNT_WIDTH{1'b0}}) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Abort wins even on an edge where a transition was due.
                    if (bus.abort) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else if (interval_r == {PERIOD_WIDTH{1'b0}}) begin
                        phase_r              <= phase_step_s;
                        {enc_a_r, enc_b_r}   <= phase_to_ab(phase_step_s);
                        position_r           <= position_step_s;
                        interval_r           <= reload_r;
                        remaining_r          <= remaining_r - COUNT_WIDTH'(1);
                        if (remaining_r == COUNT_WIDTH'(1)) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        interval_r <= interval_r - PERIOD_WIDTH'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_r;
    assign bus.enc_a     = enc_a_r;
    assign bus.enc_b     = enc_b_r;
    assign bus.position  = position_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_quad_encoder_gen.sv
// Scoreboard bench for quad_encoder_gen: stimulus pushes expected edge/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_quad_encoder_gen;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    quad_encoder_if #(.COUNT_WIDTH(8), .PERIOD_WIDTH(16)) bus ();

    quad_encoder_gen #(.COUNT_WIDTH(8), .PERIOD_WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int         kind;   // 0 = A/B edge, 1 = done pulse
        int         cyc;
        logic [1:0] ab;
        logic [7:0] pos;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    int         acc = 0;
    logic [1:0] prev_ab = 2'b00;
    logic [1:0] p_m = 2'd0;
    logic [7:0] pos_m = 8'd0;
    logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_%s: got event at cycle %0d ab=%b pos=%0h, expected none",
                     (kind != 0) ? "done" : "edge", cyc, {bus.enc_a, bus.enc_b}, bus.position);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.cyc == cyc && e.ab == {bus.enc_a, bus.enc_b} && e.pos == bus.position)
                passed++;
            else
                $display("FAIL event: got kind=%0d cyc=%0d ab=%b pos=%0h expected kind=%0d cyc=%0d ab=%b pos=%0h",
                         kind, cyc, {bus.enc_a, bus.enc_b}, bus.position, e.kind, e.cyc, e.ab, e.pos);
        end
    endtask

    // Monitor: any A/B change or done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_ab = {bus.enc_a, bus.enc_b};
        end else begin
            if ({bus.enc_a, bus.enc_b} != prev_ab) begin
                observe(0);
                prev_ab = {bus.enc_a, bus.enc_b};
            end
            if (bus.done) observe(1);
        end
    end

    task automatic push_steps(input logic dir, input int n, input int period);
        for (int k = 1; k <= n; k++) begin
            p_m   = dir ? p_m + 2'd1 : p_m - 2'd1;
            pos_m = dir ? pos_m + 8'd1 : pos_m - 8'd1;
            exp_q.push_back('{kind: 0, cyc: acc + k * period, ab: ab_tab[p_m], pos: pos_m});
        end
    endtask

    task automatic push_done(input int at);
        exp_q.push_back('{kind: 1, cyc: at, ab: ab_tab[p_m], pos: pos_m});
    endtask

    task automatic issue(input logic dir, input int steps, input int period);
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_dir    = dir;
        bus.cmd_steps  = steps[7:0];
        bus.cmd_period = period[15:0];
        @(posedge clk);
        #1;
        acc = cyc;
        bus.cmd_valid  = 1'b0;
        bus.cmd_dir    = ~dir;
        bus.cmd_steps  = 8'hA5;
        bus.cmd_period = 16'h0007;
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (exp_q.size() == 0) passed++;
        else begin
            $display("FAIL %s_timeout: got %0d pending events expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        p_m     = 2'd0;
        pos_m   = 8'd0;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_dir    = 1'b0;
        bus.cmd_steps  = 8'd0;
        bus.cmd_period = 16'd0;
        bus.abort      = 1'b0;

        // Reset held and released
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clk); #1;
        chk("rel_ab",    32'({bus.enc_a, bus.enc_b}), 32'd0);
        chk("rel_pos",   32'(bus.position), 32'd0);
        chk("rel_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rel_busy",  32'(bus.busy), 32'd0);
        chk("rel_done",  32'(bus.done), 32'd0);

        // Clockwise 4 steps, period 3: 10,11,01,00 at +3,+6,+9,+12
        issue(1'b1, 4, 3);
        chk("cw4_busy", 32'(bus.busy), 32'd1);
        chk("cw4_ready", 32'(bus.cmd_ready), 32'd0);
        push_steps(1'b1, 4, 3);
        push_done(acc + 12);
        drain("cw4", 100);
        chk("cw4_pos", 32'(bus.position), 32'h04);
        chk("cw4_ab",  32'({bus.enc_a, bus.enc_b}), 32'b00);
        @(negedge clk); #1;
        chk("cw4_ready_after", 32'(bus.cmd_ready), 32'd1);
        chk("cw4_done_after",  32'(bus.done), 32'd0);
        chk("cw4_busy_after",  32'(bus.busy), 32'd0);

        // Counter-clockwise 5 steps, period 2 from p=0: 01,11,10,00,01
        do_reset();
        issue(1'b0, 5, 2);
        push_steps(1'b0, 5, 2);
        push_done(acc + 10);
        drain("ccw5", 100);
        chk("ccw5_pos", 32'(bus.position), 32'hFB);
        chk("ccw5_ab",  32'({bus.enc_a, bus.enc_b}), 32'b01);

        // Zero steps: no edge, done in the cycle after accept
        issue(1'b1, 0, 5);
        push_done(acc);
        drain("zero", 20);
        chk("zero_ab", 32'({bus.enc_a, bus.enc_b}), 32'b01);

        // Period 0 behaves as 1: edges at +1, +2 (p 3->0->1)
        issue(1'b1, 2, 0);
        push_steps(1'b1, 2, 1);
        push_done(acc + 2);
        drain("per0", 20);
        chk("per0_pos", 32'(bus.position), 32'hFD);
        chk("per0_ab",  32'({bus.enc_a, bus.enc_b}), 32'b10);

        // Command held valid through DONE is taken on the first IDLE cycle
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_dir    = 1'b1;
        bus.cmd_steps  = 8'd0;
        bus.cmd_period = 16'd1;
        @(posedge clk); #1;
        acc = cyc;
        push_done(acc);
        push_done(acc + 2);
        repeat (2) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        drain("held", 20);

        // Abort after the 2nd edge of a 10-step command
        do_reset();
        issue(1'b1, 10, 4);
        push_steps(1'b1, 2, 4);
        while (cyc != acc + 8) @(negedge clk);
        #1;
        bus.abort = 1'b1;
        @(negedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_busy",  32'(bus.busy), 32'd0);
        repeat (30) @(negedge clk);
        #1;
        chk("abort_pos", 32'(bus.position), 32'h02);
        chk("abort_ab",  32'({bus.enc_a, bus.enc_b}), 32'b11);
        chk("abort_q",   32'(exp_q.size()), 32'd0);

        // Abort coinciding with a due edge suppresses it
        issue(1'b0, 3, 2);
        while (cyc != acc + 1) @(negedge clk);
        #1;
        bus.abort = 1'b1;
        @(negedge clk); #1;
        bus.abort = 1'b0;
        chk("abprio_ab",    32'({bus.enc_a, bus.enc_b}), 32'b11);
        chk("abprio_pos",   32'(bus.position), 32'h02);
        chk("abprio_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (10) @(negedge clk);

        // 256 clockwise edges wrap position back to 0 and phase to 00
        do_reset();
        issue(1'b1, 200, 1);
        push_steps(1'b1, 200, 1);
        push_done(acc + 200);
        drain("wrap_a", 400);
        issue(1'b1, 56, 1);
        push_steps(1'b1, 56, 1);
        push_done(acc + 56);
        drain("wrap_b", 200);
        chk("wrap_pos", 32'(bus.position), 32'h00);
        chk("wrap_ab",  32'({bus.enc_a, bus.enc_b}), 32'b00);

        // Asynchronous reset mid-RUN after two edges
        issue(1'b1, 10, 3);
        push_steps(1'b1, 2, 3);
        while (cyc != acc + 7) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ab",    32'({bus.enc_a, bus.enc_b}), 32'b00);
        chk("arst_pos",   32'(bus.position), 32'h00);
        chk("arst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("arst_busy",  32'(bus.busy), 32'd0);
        chk("arst_done",  32'(bus.done), 32'd0);
        chk("arst_q",     32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        p_m     = 2'd0;
        pos_m   = 8'd0;
        reset_n = 1'b1;

        // Operation resumes after reset release
        issue(1'b0, 1, 1);
        push_steps(1'b0, 1, 1);
        push_done(acc + 1);
        drain("resume", 20);
        chk("resume_pos", 32'(bus.position), 32'hFF);
        chk("resume_ab",  32'({bus.enc_a, bus.enc_b}), 32'b01);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/quad_encoder_gen.md
QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

Interface
REQ-001 Parameter: COUNT_WIDTH, default 8, width of the step-count field.
REQ-002 Parameter: PERIOD_WIDTH, default 16, width of the edge-period field (clocks per edge).
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  block can accept a command.
REQ-007 cmd_dir  in  1  1 = clockwise (A leads B), 0 = counter-clockwise (B leads A).
REQ-008 cmd_steps  in  COUNT_WIDTH  number of quadrature edges to emit.
REQ-009 cmd_period  in  PERIOD_WIDTH  clocks between successive edges.
REQ-010 abort  in  1  terminate the running command.
REQ-011 enc_a, enc_b  out  1 each  registered quadrature outputs.
REQ-012 position  out  8  signed net edge count, two's complement.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 done  out  1  one-cycle completion pulse.

Function
REQ-015 Outputs SHALL be driven from a 2-bit phase register p: {enc_a,enc_b} = 00 (p=0), 10 (p=1), 11 (p=2), 01 (p=3).
REQ-016 FSM states SHALL be IDLE, RUN, DONE; cmd_ready = 1 only in IDLE.
REQ-017 Accept SHALL occur on a rising edge with cmd_valid && cmd_ready; cmd_dir, cmd_steps and cmd_period are latched then, and later input changes are ignored.
REQ-018 cmd_period = 0 SHALL be treated as 1.
REQ-019 Accept with cmd_steps = 0 SHALL go IDLE -> DONE with no output transition.
REQ-020 Accept with cmd_steps != 0 SHALL go IDLE -> RUN and load the interval counter with period-1.
REQ-021 In RUN, when the counter is 0, the block SHALL advance p (+1 mod 4 if cmd_dir = 1, -1 mod 4 otherwise), update position by +1/-1, reload the counter with period-1 and decrement the remaining count; otherwise it SHALL decrement the counter.
REQ-022 The first transition SHALL be registered exactly period clocks after the accepting edge, and each subsequent transition exactly period clocks after the previous one.
REQ-023 The edge that emits the final transition SHALL also move RUN -> DONE.
REQ-024 done SHALL be 1 for exactly the one cycle spent in DONE; DONE -> IDLE is unconditional.
REQ-025 abort in RUN SHALL move to IDLE on the next edge with no further transitions and no done pulse; abort has priority over a coincident scheduled transition.
REQ-026 abort in IDLE or DONE SHALL be ignored.
REQ-027 Phase and position SHALL persist across commands; position wraps modulo 256.
REQ-028 A command held valid through DONE SHALL be accepted on the first IDLE cycle.

Reset
REQ-029 While reset_n = 0: state = IDLE, p = 0, enc_a = enc_b = 0, position = 0, counters = 0, done = 0, busy = 0, cmd_ready = 1.
REQ-030 Reset asserted mid-RUN SHALL abort immediately without a done pulse; operation resumes on the first edge after deassertion.

Verification
REQ-031 Release reset -> enc_a = 0, enc_b = 0, position = 0, cmd_ready = 1, busy = 0, done = 0.
REQ-032 dir = 1, steps = 4, period = 3 -> {a,b} = 10, 11, 01, 00 at +3, +6, +9, +12 clocks; position = 4; done high exactly 1 cycle; cmd_ready high the following cycle.
REQ-033 From p = 0: dir = 0, steps = 5, period = 2 -> 01, 11, 10, 00, 01 at 2-clock spacing; position = 0xFB (-5).
REQ-034 steps = 0 -> no output change; done pulses 1 cycle after accept. Separately, period = 0 with steps = 2 -> transitions at +1 and +2 clocks.
REQ-035 steps = 10, period = 4, abort asserted after the 2nd transition -> no further transitions; position = 2; done never asserts; cmd_ready = 1 on the next cycle.
REQ-036 Wrap and reset cases:
- 256 clockwise steps -> position = 0 and {a,b} = 00.
- reset_n pulsed low mid-RUN -> all outputs return to the REQ-029 values asynchronously.
